next_pc_unit: RTL and testbench
===============================

Name: next_pc_unit

Overview:
Parametrised next-PC generator and program-counter register for the RISC-V datapath. It generalises the two-way branch-AND PC mux in four ways:
- full RV32I branch-condition decode from funct3;
- JAL/JALR targets;
- stall support;
- a post-redirect flush sequencer with misaligned-target trap.

It sits between the fetch stage (drives `pc`) and the execute stage (consumes ALU flags and the resolved instruction's PC and immediate).

Parameters:
- XLEN, 32, datapath/address width.
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned redirect target.
- FLUSH_CYCLES, 2, cycles `flush` is held after a redirect (1..15).

Ports:
- clock, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset.
- stall, input, 1, hold PC (fetch back-pressure).
- ex_valid, input, 1, execute-stage instruction is valid.
- ex_pc, input, XLEN, PC of the instruction in execute.
- ex_imm, input, XLEN, sign-extended branch/jump immediate.
- ex_rs1, input, XLEN, rs1 value (JALR base).
- branch, input, 1, conditional branch instruction.
- jump, input, 1, JAL instruction.
- jalr, input, 1, JALR instruction.
- funct3, input, 3, branch type.
- zero, input, 1, ALU result equals zero.
- lt, input, 1, signed less-than from ALU.
- ltu, input, 1, unsigned less-than from ALU.
- pc, output, XLEN, current fetch PC.
- pc_valid, output, 1, `pc` is a fetchable, non-squashed address.
- flush, output, 1, squash younger pipeline stages.
- redirect, output, 1, one-cycle pulse: PC loaded with a taken target this cycle.
- misaligned, output, 1, one-cycle pulse: redirect target had bits[1:0] != 0.

Behaviour:
- Reset (synchronous, has priority over everything), outputs take these values:
  - `pc` = RESET_VECTOR
  - `pc_valid` = 1
  - `flush` = 0
  - `redirect` = 0
  - `misaligned` = 0
  - FSM = RUN, flush counter = 0
- Branch condition from funct3:
  - 000 BEQ = zero
  - 001 BNE = !zero
  - 100 BLT = lt
  - 101 BGE = !lt
  - 110 BLTU = ltu
  - 111 BGEU = !ltu
  - 010/011 = never taken
- take = ex_valid & (jalr | jump | (branch & cond)).
  - Priority when several flags are set: jalr > jump > branch.
- Target computation (arithmetic modulo 2^XLEN, overflow wraps silently):
  - jalr: (ex_rs1 + ex_imm) with bit 0 cleared.
  - Otherwise: ex_pc + ex_imm.
- Sequential next PC = pc + 4 (wraps at 2^XLEN).
- FSM state RUN:
  - If take and target[1:0] == 0:
    - pc <= target, redirect = 1.
    - flush counter <= FLUSH_CYCLES, go to FLUSH.
  - If take and target[1:0] != 0:
    - pc <= TRAP_VECTOR, misaligned = 1, redirect = 1.
    - Go to FLUSH with counter = FLUSH_CYCLES.
  - Else if !stall: pc <= pc + 4.
  - Else (stall): pc holds.
  - A redirect overrides stall in the same cycle.
- FSM state FLUSH:
  - `flush` = 1 and `pc_valid` = 0.
  - Execute-stage inputs are ignored: they belong to squashed instructions, so no nested redirect.
  - pc holds at the redirect target.
  - Counter decrements each cycle regardless of stall; at 1, go to RUN next cycle.
  - First RUN cycle after FLUSH: `pc_valid` = 1, pc = target. The next increment follows the normal RUN rules.
- `redirect` and `misaligned` are registered pulses, high exactly one cycle: the cycle `pc` first shows the new value.
- Latency: a taken condition sampled at edge N is visible on `pc` after edge N (same cycle as `redirect`). `flush` is high for FLUSH_CYCLES cycles starting then.
- Reset mid-FLUSH: immediately return to RUN, counter cleared, `flush` = 0.
- ex_valid = 0: `branch`/`jump`/`jalr` have no effect.

Test Plan:
- **Reset and increment.** reset for 2 cycles, then run 4 cycles with no stall → pc = 0, 4, 8, 12, 16; pc_valid = 1; flush = 0.
- **BEQ taken, then BNE not taken.**
  - BEQ taken: ex_pc = 0x40, ex_imm = 0x20, branch = 1, funct3 = 000, zero = 1 → next pc = 0x60, redirect pulse, flush high 2 cycles, pc_valid = 0 during flush, pc holds 0x60.
  - BNE not taken: same inputs with funct3 = 001 → pc = prev + 4, no flush.
- **Signed vs unsigned compare.** funct3 = 100, lt = 0, ltu = 1 → not taken. funct3 = 110, same flags → taken to ex_pc + ex_imm.
- **JALR.** jalr = 1, ex_rs1 = 0x1001, ex_imm = 0x4 → pc = 0x1004 (bit 0 cleared). With ex_imm = 0x2 → target 0x1002 is misaligned, so pc = 0x100 and a misaligned pulse fires.
- **Stall and priority.** stall = 1 for 3 cycles → pc frozen. stall = 1 together with JAL taken → redirect wins and pc = target. jump and branch both set → jump target used.
- **Flush isolation and wrap.**
  - A taken branch presented during FLUSH is ignored.
  - Reset asserted in the second FLUSH cycle → pc = RESET_VECTOR, flush = 0 next cycle.
  - pc = 0xFFFF_FFFC with no stall → pc wraps to 0.

Source files
------------

// File: rtl/next_pc_unit.sv
// ----------------------------------------------------------------------------
// next_pc_unit
//
// Next-PC generator and program-counter register for the RISC-V datapath.
// It resolves RV32I branch conditions, computes JAL/JALR/branch targets,
// advances the fetch PC by 4, honours fetch stalls, and runs a short flush
// sequence after every redirect. A redirect to a target that is not
// word-aligned is diverted to TRAP_VECTOR and flagged with a pulse.
//
// Ports
//   clock      in   system clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset, highest priority
//   stall      in   hold the PC (fetch back-pressure)
//   ex_valid   in   execute-stage instruction is valid
//   ex_pc      in   PC of the instruction in execute
//   ex_imm     in   sign-extended branch/jump immediate
//   ex_rs1     in   rs1 value, base address for JALR
//   branch     in   conditional branch instruction
//   jump       in   JAL instruction
//   jalr       in   JALR instruction
//   funct3     in   branch type
//   zero       in   ALU result equals zero
//   lt         in   signed less-than from the ALU
//   ltu        in   unsigned less-than from the ALU
//   pc         out  current fetch PC
//   pc_valid   out  pc is fetchable and not squashed
//   flush      out  squash younger pipeline stages
//   redirect   out  one-cycle pulse, pc was just loaded with a taken target
//   misaligned out  one-cycle pulse, the redirect target had bits[1:0] != 0
// ----------------------------------------------------------------------------
module next_pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            branch,
    input  logic            jump,
    input  logic            jalr,
    input  logic [2:0]      funct3,
    input  logic            zero,
    input  logic            lt,
    input  logic            ltu,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic            redirect,
    output logic            misaligned
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redirect_q, redirect_d;
    logic            misaligned_q, misaligned_d;

    logic            cond_s;
    logic            take_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] jalr_sum_s;

    // RV32I branch condition decode; the two reserved encodings never branch.
    function automatic logic branch_cond(input logic [2:0] f3,
                                         input logic       z,
                                         input logic       slt,
                                         input logic       sltu);
        logic c;
        case (f3)
            3'b000:  c = z;
            3'b001:  c = ~z;
            3'b100:  c = slt;
            3'b101:  c = ~slt;
            3'b110:  c = sltu;
            3'b111:  c = ~sltu;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    // Taken decision and target address; jalr outranks jump and branch.
    always_comb begin
        cond_s     = branch_cond(funct3, zero, lt, ltu);
        take_s     = ex_valid & (jalr | jump | (branch & cond_s));
        jalr_sum_s = ex_rs1 + ex_imm;
        if (jalr) begin
            target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
        end else begin
            target_s = ex_pc + ex_imm;
        end
    end

    // State register: PC, FSM state, flush counter and the registered pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            cnt_q        <= 4'd0;
            pc_q         <= RESET_VECTOR;
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            redirect_q   <= redirect_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Next-state logic. In FLUSH the execute inputs are stale (they belong
    // to squashed instructions), so they are not looked at and stall does
    // not slow the countdown.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        redirect_d   = 1'b0;
        misaligned_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (take_s) begin
                    redirect_d = 1'b1;
                    state_d    = ST_FLUSH;
                    cnt_d      = FLUSH_INIT;
                    if (target_s[1:0] == 2'b00) begin
                        pc_d = target_s;
                    end else begin
                        pc_d         = TRAP_VECTOR;
                        misaligned_d = 1'b1;
                    end
                end else if (!stall) begin
                    pc_d = pc_q + XLEN'(32'd4);
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_FLUSH: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output decode, driven only from registered state.
    always_comb begin
        pc         = pc_q;
        redirect   = redirect_q;
        misaligned = misaligned_q;
        case (state_q)
            ST_RUN: begin
                flush    = 1'b0;
                pc_valid = 1'b1;
            end
            ST_FLUSH: begin
                flush    = 1'b1;
                pc_valid = 1'b0;
            end
            default: begin
                flush    = 1'b0;
                pc_valid = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_next_pc_unit
//
// Directed bench for next_pc_unit with default parameters (XLEN 32,
// reset vector 0, trap vector 0x100, two flush cycles). Inputs change
// 1 ns after a rising edge and outputs are checked at that same point,
// so every check sees the state produced by the preceding edge.
// ----------------------------------------------------------------------------
module tb_next_pc_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  funct3;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        redirect;
    logic        misaligned;

    int checks;
    int errors;

    next_pc_unit dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .ex_pc      (ex_pc),
        .ex_imm     (ex_imm),
        .ex_rs1     (ex_rs1),
        .branch     (branch),
        .jump       (jump),
        .jalr       (jalr),
        .funct3     (funct3),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .flush      (flush),
        .redirect   (redirect),
        .misaligned (misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check pc plus all four status bits in one call.
    task automatic chk_all(input string tag, input logic [31:0] exp_pc,
                           input logic exp_vld, input logic exp_fl,
                           input logic exp_rd, input logic exp_mis);
        chk({tag, ".pc"}, pc, exp_pc);
        chk({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, exp_vld});
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, exp_fl});
        chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, exp_rd});
        chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, exp_mis});
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        stall    = 1'b0;
        ex_valid = 1'b0;
        ex_pc    = 32'd0;
        ex_imm   = 32'd0;
        ex_rs1   = 32'd0;
        branch   = 1'b0;
        jump     = 1'b0;
        jalr     = 1'b0;
        funct3   = 3'b000;
        zero     = 1'b0;
        lt       = 1'b0;
        ltu      = 1'b0;

        // Reset for two cycles, then sequential increments.
        tick();
        tick();
        chk_all("reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); chk_all("inc4",  32'h4,  1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("inc8",  32'h8,  1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("inc12", 32'hC,  1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("inc16", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);

        // BEQ taken: 0x40 + 0x20.
        ex_valid = 1'b1; ex_pc = 32'h40; ex_imm = 32'h20;
        branch = 1'b1; funct3 = 3'b000; zero = 1'b1;
        tick(); chk_all("beq_taken", 32'h60, 1'b0, 1'b1, 1'b1, 1'b0);
        // Same taken branch still presented during FLUSH: ignored.
        tick(); chk_all("flush_ignore", 32'h60, 1'b0, 1'b1, 1'b0, 1'b0);
        funct3 = 3'b001;
        tick(); chk_all("flush_done", 32'h60, 1'b1, 1'b0, 1'b0, 1'b0);
        // BNE with zero=1: not taken.
        tick(); chk_all("bne_not", 32'h64, 1'b1, 1'b0, 1'b0, 1'b0);

        // Signed vs unsigned compare: lt=0, ltu=1.
        zero = 1'b0; lt = 1'b0; ltu = 1'b1; funct3 = 3'b100;
        tick(); chk_all("blt_not", 32'h68, 1'b1, 1'b0, 1'b0, 1'b0);
        funct3 = 3'b110;
        tick(); chk_all("bltu_taken", 32'h60, 1'b0, 1'b1, 1'b1, 1'b0);
        ex_valid = 1'b0;
        tick();
        tick(); chk_all("bltu_settle", 32'h60, 1'b1, 1'b0, 1'b0, 1'b0);
        // Branch flags with ex_valid low have no effect.
        tick(); chk_all("exvalid_gate", 32'h64, 1'b1, 1'b0, 1'b0, 1'b0);

        // JALR: 0x1001 + 4 = 0x1005, bit 0 cleared -> 0x1004.
        branch = 1'b0; jalr = 1'b1; ex_valid = 1'b1;
        ex_rs1 = 32'h1001; ex_imm = 32'h4;
        tick(); chk_all("jalr", 32'h1004, 1'b0, 1'b1, 1'b1, 1'b0);
        ex_valid = 1'b0;
        tick();
        tick(); chk_all("jalr_settle", 32'h1004, 1'b1, 1'b0, 1'b0, 1'b0);
        // JALR to 0x1002: misaligned, trap to 0x100.
        ex_valid = 1'b1; ex_imm = 32'h2;
        tick(); chk_all("jalr_mis", 32'h100, 1'b0, 1'b1, 1'b1, 1'b1);
        ex_valid = 1'b0;
        tick(); chk_all("mis_pulse_end", 32'h100, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("mis_settle", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);

        // Stall holds pc for three cycles.
        jalr = 1'b0; stall = 1'b1;
        tick(); chk_all("stall1", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("stall2", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("stall3", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        // JAL under stall, with a not-taken branch flag also set: jump wins.
        ex_valid = 1'b1; jump = 1'b1; branch = 1'b1; funct3 = 3'b001; zero = 1'b1;
        ex_pc = 32'h200; ex_imm = 32'h10;
        tick(); chk_all("jal_stall", 32'h210, 1'b0, 1'b1, 1'b1, 1'b0);
        ex_valid = 1'b0; stall = 1'b0; branch = 1'b0;
        tick();
        tick(); chk_all("jal_settle", 32'h210, 1'b1, 1'b0, 1'b0, 1'b0);
        // jalr and jump together: JALR target 0x300+0x10, not 0x200+0x10.
        ex_valid = 1'b1; jalr = 1'b1; ex_rs1 = 32'h300;
        tick(); chk_all("jalr_prio", 32'h310, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset in the second FLUSH cycle.
        ex_valid = 1'b0; jalr = 1'b0; jump = 1'b0;
        tick(); chk_all("flush2", 32'h310, 1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick(); chk_all("reset_in_flush", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Jump to 0xFFFF_FFFC and let pc wrap to 0.
        ex_valid = 1'b1; jump = 1'b1; ex_pc = 32'h0; ex_imm = 32'hFFFF_FFFC;
        tick(); chk_all("jal_top", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b0);
        ex_valid = 1'b0; jump = 1'b0;
        tick();
        tick(); chk_all("top_settle", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
